// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the hardwired control unit: opcodes, FSM states,
// instruction classes and ALU selects.
package cpu_ctrl_pkg;

  localparam int unsigned OP_W = 5;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b01010;
  localparam logic [OP_W-1:0] OP_OR   = 5'b01011;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    RESET = 4'd0, T0 = 4'd1, T1 = 4'd2, T2 = 4'd3, T3 = 4'd4,
    T4 = 4'd5, T5 = 4'd6, T6 = 4'd7, T7 = 4'd8, HALT = 4'd9
  } state_e;

  typedef enum logic [2:0] {RALU, IMM, LDI, LD, ST, NOP, HLT} iclass_e;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} alu_e;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode to instruction-class and ALU-select mapping; unknown opcodes fall to NOP.
module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPW = 5
) (
  input  logic [OPW-1:0] op_i,
  output iclass_e        cls_o,
  output alu_e           alu_o
);

  always_comb begin
    cls_o = NOP;
    alu_o = ALU_ADD;
    case (op_i)
      OPW'(OP_LD):   cls_o = LD;
      OPW'(OP_LDI):  cls_o = LDI;
      OPW'(OP_ST):   cls_o = ST;
      OPW'(OP_ADD):  cls_o = RALU;
      OPW'(OP_SUB):  begin cls_o = RALU; alu_o = ALU_SUB; end
      OPW'(OP_AND):  begin cls_o = RALU; alu_o = ALU_AND; end
      OPW'(OP_OR):   begin cls_o = RALU; alu_o = ALU_OR;  end
      OPW'(OP_ADDI): cls_o = IMM;
      OPW'(OP_ANDI): begin cls_o = IMM;  alu_o = ALU_AND; end
      OPW'(OP_ORI):  begin cls_o = IMM;  alu_o = ALU_OR;  end
      OPW'(OP_HALT): cls_o = HLT;
      default:       cls_o = NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control unit for the single-bus datapath: fetch, decode and
// execute sequencing with one-hot strobes decoded from state and opcode.
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPW = 5
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        stop,
  output logic        run,
  output logic        dp_clear,
  output logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread,
  output logic        RAMread, RAMwrite, IRin, Yin, Zlowin, Zlowout, CSEout,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout,
  output logic        ADD, SUB, AND, OR,
  output logic        HIin, LOin, HIout, LOout, Zhighin, Zhighout, InPortout,
  output logic        OutPortin, CONin, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT
);

  state_e         state_q;
  logic [OPW-1:0] op_q;
  logic [OPW-1:0] op_cur;
  iclass_e        cls;
  alu_e           alu;
  logic           unused_ir;

  // IR is valid from the T2 edge, so T3 decodes it live; later states use op_q.
  assign op_cur    = (state_q == T3) ? ir[31 -: OPW] : op_q;
  assign unused_ir = ^ir[31-OPW:0];

  ctrl_decode #(.OPW(OPW)) u_decode (
    .op_i  (op_cur),
    .cls_o (cls),
    .alu_o (alu)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= RESET;
      op_q    <= '0;
    end else begin
      unique case (state_q)
        RESET: state_q <= T0;
        T0:    state_q <= T1;
        T1:    state_q <= T2;
        T2:    state_q <= T3;
        T3: begin
          op_q <= op_cur;
          case (cls)
            HLT:     state_q <= HALT;
            NOP:     state_q <= stop ? HALT : T0;
            default: state_q <= T4;
          endcase
        end
        T4:    state_q <= T5;
        T5:    state_q <= (cls == LD || cls == ST) ? T6 : (stop ? HALT : T0);
        T6:    state_q <= T7;
        T7:    state_q <= stop ? HALT : T0;
        HALT:  state_q <= HALT;
        default: state_q <= RESET;
      endcase
    end
  end

  // Strobe decode; anything not set for a state stays low.
  always_comb begin
    {run, dp_clear, PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread,
     RAMread, RAMwrite, IRin, Yin, Zlowin, Zlowout, CSEout, Gra, Grb, Grc,
     Rin, Rout, BAout, ADD, SUB, AND, OR} = '0;
    run = (state_q >= T0) && (state_q <= T7);
    case (state_q)
      RESET: dp_clear = 1'b1;
      T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1; end
      T1: begin
        Zlowout = 1'b1; PCin = 1'b1; MDMuxread = 1'b1; RAMread = 1'b1; MDRin = 1'b1;
      end
      T2: begin MDRout = 1'b1; IRin = 1'b1; end
      T3: begin
        if (cls == RALU || cls == IMM) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (cls == LDI || cls == LD || cls == ST) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end
      end
      T4: begin
        if (cls == RALU) begin
          Grc = 1'b1; Rout = 1'b1;
        end else begin
          CSEout = 1'b1;
        end
        {ADD, SUB, AND, OR} = 4'b1000 >> alu;
        Zlowin = 1'b1;
      end
      T5: begin
        Zlowout = 1'b1;
        if (cls == LD || cls == ST) MARin = 1'b1;
        else begin Gra = 1'b1; Rin = 1'b1; end
      end
      T6: begin
        MDRin = 1'b1;
        if (cls == ST) begin Gra = 1'b1; Rout = 1'b1; end
        else begin MDMuxread = 1'b1; RAMread = 1'b1; end
      end
      T7: begin
        if (cls == ST) RAMwrite = 1'b1;
        else begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      end
      default: ;
    endcase
  end

  assign {HIin, LOin, HIout, LOout, Zhighin, Zhighout, InPortout, OutPortin,
          CONin, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT} = '0;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus queues the expected strobe word
// per cycle, a negedge monitor pops and compares what the DUT shows.
module tb_control_unit;

  logic clock = 1'b0;
  logic clear, stop;
  logic [31:0] ir;
  logic run, dp_clear, PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread;
  logic RAMread, RAMwrite, IRin, Yin, Zlowin, Zlowout, CSEout, Gra, Grb, Grc;
  logic Rin, Rout, BAout, ADD, SUB, AND, OR;
  logic HIin, LOin, HIout, LOout, Zhighin, Zhighout, InPortout, OutPortin;
  logic CONin, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;

  always #5 clock = ~clock;

  control_unit #(.OPW(5)) dut (
    .clock(clock), .clear(clear), .ir(ir), .stop(stop), .run(run), .dp_clear(dp_clear),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .MDMuxread(MDMuxread), .RAMread(RAMread), .RAMwrite(RAMwrite),
    .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin), .Zlowout(Zlowout), .CSEout(CSEout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR),
    .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout), .Zhighin(Zhighin),
    .Zhighout(Zhighout), .InPortout(InPortout), .OutPortin(OutPortin), .CONin(CONin),
    .MUL(MUL), .DIV(DIV), .SHR(SHR), .SHRA(SHRA), .SHL(SHL), .ROR(ROR), .ROL(ROL),
    .NEG(NEG), .NOT(NOT)
  );

  localparam logic [26:0] M_RUN = 27'h1 << 26, M_DPC = 27'h1 << 25, M_PCO = 27'h1 << 24;
  localparam logic [26:0] M_PCI = 27'h1 << 23, M_INC = 27'h1 << 22, M_MAR = 27'h1 << 21;
  localparam logic [26:0] M_MDI = 27'h1 << 20, M_MDO = 27'h1 << 19, M_MUX = 27'h1 << 18;
  localparam logic [26:0] M_RRD = 27'h1 << 17, M_RWR = 27'h1 << 16, M_IRI = 27'h1 << 15;
  localparam logic [26:0] M_YIN = 27'h1 << 14, M_ZLI = 27'h1 << 13, M_ZLO = 27'h1 << 12;
  localparam logic [26:0] M_CSE = 27'h1 << 11, M_GRA = 27'h1 << 10, M_GRB = 27'h1 << 9;
  localparam logic [26:0] M_GRC = 27'h1 << 8,  M_RIN = 27'h1 << 7,  M_ROU = 27'h1 << 6;
  localparam logic [26:0] M_BAO = 27'h1 << 5,  M_ADD = 27'h1 << 4,  M_SUB = 27'h1 << 3;
  localparam logic [26:0] M_AND = 27'h1 << 2,  M_OR  = 27'h1 << 1;

  localparam logic [26:0] E_RST = M_DPC;
  localparam logic [26:0] E_F0  = M_RUN | M_PCO | M_MAR | M_INC | M_ZLI;
  localparam logic [26:0] E_F1  = M_RUN | M_ZLO | M_PCI | M_MUX | M_RRD | M_MDI;
  localparam logic [26:0] E_F2  = M_RUN | M_MDO | M_IRI;
  localparam logic [26:0] E_R3  = M_RUN | M_GRB | M_ROU | M_YIN;
  localparam logic [26:0] E_L3  = M_RUN | M_GRB | M_BAO | M_YIN;
  localparam logic [26:0] E_I4  = M_RUN | M_CSE | M_ZLI;
  localparam logic [26:0] E_R4  = M_RUN | M_GRC | M_ROU | M_ZLI;
  localparam logic [26:0] E_WB  = M_RUN | M_ZLO | M_GRA | M_RIN;
  localparam logic [26:0] E_L5  = M_RUN | M_ZLO | M_MAR;
  localparam logic [26:0] E_L6  = M_RUN | M_MUX | M_RRD | M_MDI;
  localparam logic [26:0] E_L7  = M_RUN | M_MDO | M_GRA | M_RIN;
  localparam logic [26:0] E_S6  = M_RUN | M_GRA | M_ROU | M_MDI;
  localparam logic [26:0] E_S7  = M_RUN | M_RWR;
  localparam logic [26:0] E_HLT = 27'h0;

  typedef struct {
    logic [26:0] v;
    string       name;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  logic [26:0] obs;
  assign obs = {run, dp_clear, PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread,
                RAMread, RAMwrite, IRin, Yin, Zlowin, Zlowout, CSEout, Gra, Grb, Grc,
                Rin, Rout, BAout, ADD, SUB, AND, OR,
                |{HIin, LOin, HIout, LOout, Zhighin, Zhighout, InPortout, OutPortin,
                  CONin, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT}};

  // Monitor: compare whatever the DUT drives this cycle against the queued word.
  always @(negedge clock) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (obs !== e.v) begin
        bad++;
        $display("FAIL %s: got %b want %b", e.name, obs, e.v);
      end
    end
  end

  task automatic cyc(input logic [26:0] v, input string n);
    exp_t e;
    e.v = v;
    e.name = n;
    sb.push_back(e);
    @(posedge clock);
    #2;
  endtask

  task automatic fetch(input string n);
    cyc(E_F0, {n, "_T0"});
    cyc(E_F1, {n, "_T1"});
    cyc(E_F2, {n, "_T2"});
  endtask

  task automatic do_ralu(input logic [4:0] opc, input logic [26:0] opm, input string n);
    ir = {opc, 4'd3, 4'd1, 4'd2, 15'h0};
    fetch(n);
    cyc(E_R3, {n, "_T3"});
    cyc(E_R4 | opm, {n, "_T4"});
    cyc(E_WB, {n, "_T5"});
  endtask

  task automatic do_imm(input logic [4:0] opc, input logic [26:0] opm, input string n);
    ir = {opc, 4'd3, 4'd4, 19'h00053};
    fetch(n);
    cyc(E_R3, {n, "_T3"});
    cyc(E_I4 | opm, {n, "_T4"});
    cyc(E_WB, {n, "_T5"});
  endtask

  initial begin
    clear = 1'b1;
    stop  = 1'b0;
    ir    = 32'h0;
    @(posedge clock);
    #2;
    cyc(E_RST, "rst_hold");
    clear = 1'b0;
    cyc(E_RST, "rst_release");

    // ldi R4,0xFF00 then ori R3,R4,0x53
    ir = {5'b00001, 4'd4, 4'd0, 19'h0FF00};
    fetch("ldi");
    cyc(E_L3, "ldi_T3");
    cyc(E_I4 | M_ADD, "ldi_T4");
    cyc(E_WB, "ldi_T5");
    do_imm(5'b01110, M_OR, "ori");

    // ld R1,0x10(R0)
    ir = {5'b00000, 4'd1, 4'd0, 19'h00010};
    fetch("ld");
    cyc(E_L3, "ld_T3");
    cyc(E_I4 | M_ADD, "ld_T4");
    cyc(E_L5, "ld_T5");
    cyc(E_L6, "ld_T6");
    cyc(E_L7, "ld_T7");

    // st 0x20(R0),R2
    ir = {5'b00010, 4'd2, 4'd0, 19'h00020};
    fetch("st");
    cyc(E_L3, "st_T3");
    cyc(E_I4 | M_ADD, "st_T4");
    cyc(E_L5, "st_T5");
    cyc(E_S6, "st_T6");
    cyc(E_S7, "st_T7");

    do_ralu(5'b00011, M_ADD, "add");
    do_ralu(5'b00100, M_SUB, "sub");
    do_ralu(5'b01010, M_AND, "and");
    do_ralu(5'b01011, M_OR,  "or");
    do_imm(5'b01100, M_ADD, "addi");
    do_imm(5'b01101, M_AND, "andi");

    // Illegal opcode and nop both run as 4-cycle nops
    ir = {5'b11111, 27'h0};
    fetch("ill");
    cyc(M_RUN, "ill_T3");
    ir = {5'b11010, 27'h0};
    fetch("nop");
    cyc(M_RUN, "nop_T3");

    // stop raised in T4 of an add takes effect only after T5
    ir = {5'b00011, 4'd5, 4'd6, 4'd7, 15'h0};
    fetch("stp");
    cyc(E_R3, "stp_T3");
    stop = 1'b1;
    cyc(E_R4 | M_ADD, "stp_T4");
    cyc(E_WB, "stp_T5");
    stop = 1'b0;
    cyc(E_HLT, "stp_halt0");
    cyc(E_HLT, "stp_halt1");
    clear = 1'b1;
    cyc(E_HLT, "stp_halt_clr");
    clear = 1'b0;
    cyc(E_RST, "stp_reset");

    // clear during T6 of a store aborts it before RAMwrite
    ir = {5'b00010, 4'd2, 4'd0, 19'h00020};
    fetch("stc");
    cyc(E_L3, "stc_T3");
    cyc(E_I4 | M_ADD, "stc_T4");
    cyc(E_L5, "stc_T5");
    clear = 1'b1;
    cyc(E_S6, "stc_T6");
    clear = 1'b0;
    cyc(E_RST, "stc_reset");

    // halt opcode: run drops after T3 and HALT holds
    ir = {5'b11011, 27'h0};
    fetch("hlt");
    cyc(M_RUN, "hlt_T3");
    for (int i = 0; i < 20; i++) cyc(E_HLT, "hlt_hold");
    clear = 1'b1;
    cyc(E_HLT, "hlt_clr");
    clear = 1'b0;
    cyc(E_RST, "hlt_reset");
    fetch("post");

    repeat (3) @(posedge clock);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
